// File: rtl/rf_wb_arbiter.sv
// Arbitrates the single register-file write port between requesters A (ALU) and B (load unit).
// Optional macro RF_WB_ZERO_REG_EN: accepted writes to register 0 are dropped instead of issued.
module rf_wb_arbiter #(
    parameter int unsigned CNT_W      = 16,
    parameter bit          FIXED_PRIO = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hold,
    input  logic             a_valid,
    output logic             a_ready,
    input  logic [4:0]       a_reg,
    input  logic [31:0]      a_data,
    input  logic             b_valid,
    output logic             b_ready,
    input  logic [4:0]       b_reg,
    input  logic [31:0]      b_data,
    output logic             write,
    output logic [4:0]       writereg,
    output logic [31:0]      data,
    output logic             last_b,
    output logic [CNT_W-1:0] wr_count
);

    localparam int unsigned REG_W  = 5;
    localparam int unsigned DATA_W = 32;

    logic              r_ptr_b;
    logic              r_write;
    logic [REG_W-1:0]  r_writereg;
    logic [DATA_W-1:0] r_data;
    logic              r_last_b;
    logic [CNT_W-1:0]  r_wr_count;

    logic              w_a_grant;
    logic              w_b_grant;
    logic              w_xfer;
    logic              w_do_write;
    logic [REG_W-1:0]  w_sel_reg;
    logic [DATA_W-1:0] w_sel_data;

    // Grant selection: r_ptr_b set means B owns the tie-break this cycle.
    always_comb begin
        w_a_grant = 1'b0;
        w_b_grant = 1'b0;
        if (!rst && !hold) begin
            if (a_valid && b_valid) begin
                if (FIXED_PRIO || !r_ptr_b) begin
                    w_a_grant = 1'b1;
                end else begin
                    w_b_grant = 1'b1;
                end
            end else begin
                w_a_grant = a_valid;
                w_b_grant = b_valid;
            end
        end
        w_xfer     = w_a_grant | w_b_grant;
        w_sel_reg  = w_b_grant ? b_reg  : a_reg;
        w_sel_data = w_b_grant ? b_data : a_data;
`ifdef RF_WB_ZERO_REG_EN
        w_do_write = w_xfer && (w_sel_reg != REG_W'(0));
`else
        w_do_write = w_xfer;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr_b    <= 1'b0;
            r_write    <= 1'b0;
            r_writereg <= '0;
            r_data     <= '0;
            r_last_b   <= 1'b0;
            r_wr_count <= '0;
        end else begin
            r_write <= w_do_write;
            if (w_do_write) begin
                r_writereg <= w_sel_reg;
                r_data     <= w_sel_data;
                r_wr_count <= r_wr_count + CNT_W'(1);
            end
            // Any grant hands the tie-break to the other requester.
            if (w_xfer) begin
                r_ptr_b  <= w_a_grant;
                r_last_b <= w_b_grant;
            end
        end
    end

    assign a_ready  = w_a_grant;
    assign b_ready  = w_b_grant;
    assign write    = r_write;
    assign writereg = r_writereg;
    assign data     = r_data;
    assign last_b   = r_last_b;
    assign wr_count = r_wr_count;

endmodule
